// File: rtl/tick_timer_arbiter.sv
// Shared one-shot delay timer with a round-robin arbiter for four requesters.
// Optional: define TIMER_CANCEL_EN to let the owner abort a run by dropping Req.
module tick_timer_arbiter #(
    parameter int DivVal = 10000,
    parameter int CntW   = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [3:0]          Req,
    input  logic [4*CntW-1:0]   Delay,
    output logic [3:0]          Gnt,
    output logic [3:0]          Done,
    output logic                Busy,
    output logic                Tick
);

    localparam int PW = (DivVal < 1) ? 1 : $clog2(DivVal + 1);
    localparam logic [PW-1:0] DivTc = PW'(DivVal);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t          state, stateNext;
    logic [1:0]      ptr, ptrNext;
    logic [1:0]      owner, ownerNext;
    logic [PW-1:0]   presc, prescNext;
    logic [CntW-1:0] cnt, cntNext;

    logic [1:0]      pick;
    logic [1:0]      idx;
    logic            found;
    logic            atTc;
    logic [3:0]      ownerHot;

    // Round-robin scan starting at ptr; the first set request wins.
    always_comb begin
        pick  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign atTc     = (presc == DivTc);
    assign ownerHot = 4'b0001 << owner;

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        ownerNext = owner;
        prescNext = presc;
        cntNext   = cnt;
        case (state)
            StIdle: begin
                if (found) begin
                    ownerNext = pick;
                    cntNext   = Delay[pick*CntW +: CntW];
                    prescNext = '0;
                    stateNext = StRun;
                end
            end
            StRun: begin
                prescNext = atTc ? '0 : presc + 1'b1;
                if (atTc && cnt != '0)
                    cntNext = cnt - 1'b1;
`ifdef TIMER_CANCEL_EN
                if (!Req[owner]) begin
                    stateNext = StIdle;
                    ptrNext   = owner + 2'd1;
                end else
`endif
                // A zero load finishes on the first RUN cycle without a tick.
                if (cnt == '0 || (atTc && cnt == CntW'(1)))
                    stateNext = StDone;
            end
            StDone: begin
                ptrNext   = owner + 2'd1;
                stateNext = StIdle;
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= StIdle;
            ptr   <= 2'd0;
            owner <= 2'd0;
            presc <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            owner <= ownerNext;
            presc <= prescNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        Gnt  = (state == StRun)  ? ownerHot : 4'b0000;
        Done = (state == StDone) ? ownerHot : 4'b0000;
        Busy = (state != StIdle);
        Tick = (state == StRun) && atTc;
    end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Scoreboard bench for tick_timer_arbiter with DivVal=3 (tick period 4) and CntW=16.
module tb_tick_timer_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [63:0] Delay;
    logic [3:0]  Gnt;
    logic [3:0]  Done;
    logic        Busy;
    logic        Tick;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [3:0] gnt;
        int         len;
        int         ticks;
        logic [3:0] done;
        int         gap;
    } exp_t;

    exp_t sb[$];

    tick_timer_arbiter #(.DivVal(3), .CntW(16)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Req   (Req),
        .Delay (Delay),
        .Gnt   (Gnt),
        .Done  (Done),
        .Busy  (Busy),
        .Tick  (Tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [15:0] d3);
        Req   = req;
        Delay = {d3, d2, d1, d0};
    endtask

    task automatic pushExp(input logic [3:0] g, input int len, input int ticks,
                           input logic [3:0] d, input int gap);
        exp_t e;
        e.gnt = g; e.len = len; e.ticks = ticks; e.done = d; e.gap = gap;
        sb.push_back(e);
    endtask

    // Returns at the negedge of the cycle where Done is high.
    task automatic waitDone(input int maxCycles);
        bit seen = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge Clk);
            if (Done != 4'b0000) seen = 1;
        end
        if (!seen) checkOutput("waitDone timeout", 0, 1);
    endtask

    task automatic waitGnt(input int maxCycles);
        bit seen = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge Clk);
            if (Gnt != 4'b0000) seen = 1;
        end
        if (!seen) checkOutput("waitGnt timeout", 0, 1);
    endtask

    // Monitor: measures each grant segment and compares it against the scoreboard.
    bit         inSeg = 0;
    logic [3:0] segGnt;
    int         segLen, segTicks, segGap;
    int         lowCnt = 0;

    always @(negedge Clk) begin
        if (Rst) begin
            inSeg  = 0;
            lowCnt = 0;
        end else if (Gnt != 4'b0000) begin
            if (!inSeg) begin
                inSeg    = 1;
                segGnt   = Gnt;
                segLen   = 0;
                segTicks = 0;
                segGap   = lowCnt;
            end
            if (Gnt != segGnt) checkOutput("gnt stable in segment", int'(Gnt), int'(segGnt));
            segLen++;
            if (Tick) segTicks++;
            lowCnt = 0;
        end else begin
            if (inSeg) begin
                inSeg = 0;
                if (sb.size() == 0) begin
                    checkOutput("unexpected grant segment", int'(segGnt), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("grant owner", int'(segGnt), int'(e.gnt));
                    checkOutput("grant length", segLen, e.len);
                    checkOutput("ticks in grant", segTicks, e.ticks);
                    checkOutput("done after grant", int'(Done), int'(e.done));
                    if (e.gap >= 0) checkOutput("idle gap before grant", segGap, e.gap);
                end
            end else begin
                if (Done != 4'b0000) checkOutput("stray done", int'(Done), 0);
            end
            if (Tick) checkOutput("tick outside run", 1, 0);
            lowCnt++;
        end
    end

    initial begin
        Rst = 1'b0;
        applyStimulus(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        #1 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        // Reset state, and outputs stay quiet with no requests.
        repeat (3) begin
            @(negedge Clk);
            checkOutput("idle gnt", int'(Gnt), 0);
            checkOutput("idle busy", int'(Busy), 0);
        end

        // Single request: 5 ticks of 4 cycles.
        @(posedge Clk); #1;
        pushExp(4'b0001, 20, 5, 4'b0001, -1);
        applyStimulus(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
        waitGnt(5);
        checkOutput("busy in run", int'(Busy), 1);
        waitDone(40);
        checkOutput("busy in done", int'(Busy), 1);
        @(posedge Clk); #1;
        Req = 4'b0000;
        @(negedge Clk);
        checkOutput("busy falls after done", int'(Busy), 0);

        // Zero delay: one RUN cycle then Done.
        @(posedge Clk); #1;
        pushExp(4'b0100, 1, 0, 4'b0100, -1);
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'd0, 16'd0);
        waitDone(10);
        @(posedge Clk); #1;
        Req = 4'b0000;
        repeat (2) @(posedge Clk);

        // Mid-run async reset with ptr at 3; the next scan must start at 0.
        #1 applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd5);
        waitGnt(5);
        repeat (5) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        checkOutput("async reset gnt", int'(Gnt), 0);
        checkOutput("async reset busy", int'(Busy), 0);
        checkOutput("async reset done", int'(Done), 0);
        checkOutput("async reset tick", int'(Tick), 0);
        Req = 4'b0000;
        @(posedge Clk); #1 Rst = 1'b0;
        @(posedge Clk); #1;
        pushExp(4'b0010, 8, 2, 4'b0010, -1);
        applyStimulus(4'b1010, 16'd0, 16'd2, 16'd0, 16'd2);
        waitDone(20);
        @(posedge Clk); #1;
        Req = 4'b0000;
        repeat (2) @(posedge Clk);

        // Fairness after wrap: grant 3, then 0 wins over a still-pending 3.
        #1;
        pushExp(4'b1000, 4, 1, 4'b1000, -1);
        pushExp(4'b0001, 4, 1, 4'b0001, 2);
        pushExp(4'b1000, 4, 1, 4'b1000, 2);
        applyStimulus(4'b1000, 16'd1, 16'd1, 16'd1, 16'd1);
        waitDone(10);
        @(posedge Clk); #1 Req = 4'b1001;
        waitDone(10);
        @(posedge Clk); #1 Req = 4'b1000;
        waitDone(10);
        @(posedge Clk); #1 Req = 4'b0000;
        repeat (2) @(posedge Clk);

        // Round-robin with all four requesting: 0,1,2,3,0.
        #1;
        pushExp(4'b0001, 4, 1, 4'b0001, -1);
        pushExp(4'b0010, 4, 1, 4'b0010, 2);
        pushExp(4'b0100, 4, 1, 4'b0100, 2);
        pushExp(4'b1000, 4, 1, 4'b1000, 2);
        pushExp(4'b0001, 4, 1, 4'b0001, 2);
        applyStimulus(4'b1111, 16'd1, 16'd1, 16'd1, 16'd1);
        for (int n = 0; n < 5; n++) waitDone(10);
        @(posedge Clk); #1 Req = 4'b0000;
        repeat (2) @(posedge Clk);

        // Owner drops Req 7 cycles after grant.
        #1;
`ifdef TIMER_CANCEL_EN
        pushExp(4'b0010, 8, 2, 4'b0000, -1);
`else
        pushExp(4'b0010, 40, 10, 4'b0010, -1);
`endif
        applyStimulus(4'b0010, 16'd0, 16'd10, 16'd0, 16'd0);
        waitGnt(5);
        repeat (7) @(posedge Clk);
        #1 Req = 4'b0000;
        repeat (45) @(posedge Clk);

        checkOutput("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
